memory_wb: RTL and testbench

Memory stage plus W pipeline register of the Y86-64 pipelined processor: the producer side of the decode stage's forwarding and register-file write interface. It takes the M register contents and performs the data-memory read or write. It drives `m_valM` and `m_stat` combinationally for forwarding and control. On each clock edge it loads the W register, whose `W_*` fields feed decode's forwarding muxes and register-file write port.

---
 rtl/y86_pkg.sv | 43 ++++
 rtl/memory_wb_if.sv | 31 +++
 rtl/memory_wb_data_mem.sv | 42 ++++
 rtl/memory_wb.sv | 78 +++++++
 tb/tb_memory_wb.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline constants: instruction codes, one-hot status codes,
// and the W register layout together with its bubble value.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [0:3] STAT_AOK = 4'b1000;
  localparam logic [0:3] STAT_HLT = 4'b0100;
  localparam logic [0:3] STAT_ADR = 4'b0010;
  localparam logic [0:3] STAT_INS = 4'b0001;

  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic [0:3]  stat;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } w_reg_t;

  localparam w_reg_t W_BUBBLE = '{
    stat:  STAT_AOK,
    icode: I_NOP,
    valE:  64'd0,
    valM:  64'd0,
    dstE:  RNONE,
    dstM:  RNONE
  };

endpackage

// File: rtl/memory_wb_if.sv
// M-register inputs and W-register / forwarding outputs of the memory stage.
interface memory_wb_if;
  logic [0:3]  M_stat;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic        W_stall;

  logic [63:0] m_valM;
  logic [0:3]  m_stat;
  logic [0:3]  W_stat;
  logic [3:0]  W_icode;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;
  logic        halted;

  modport slave (
    input  M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM, W_stall,
    output m_valM, m_stat, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, halted
  );

  modport master (
    output M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM, W_stall,
    input  m_valM, m_stat, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, halted
  );
endinterface

// File: rtl/memory_wb_data_mem.sv
// Byte-addressed little-endian data memory: combinational 64-bit read,
// synchronous 64-bit write, address range checking.
module data_mem #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic [63:0] addr_i,
  input  logic        access_i,
  input  logic        we_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] rdata_o,
  output logic        dmem_error_o
);
  localparam int AW = $clog2(MEM_BYTES);

  logic [7:0]    mem [MEM_BYTES];
  logic          addr_valid;
  logic [AW-1:0] base;

  // 65-bit sum so addresses near 2^64 cannot wrap into range.
  assign addr_valid   = ({1'b0, addr_i} + 65'd7) < 65'(MEM_BYTES);
  assign dmem_error_o = access_i && !addr_valid;
  assign base         = addr_i[AW-1:0];

  always_comb begin
    rdata_o = '0;
    if (addr_valid) begin
      for (int k = 0; k < 8; k++) begin
        rdata_o[8*k +: 8] = mem[base + AW'(k)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we_i && addr_valid) begin
      for (int k = 0; k < 8; k++) begin
        mem[base + AW'(k)] <= wdata_i[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/memory_wb.sv
// Y86-64 memory stage plus W pipeline register: data-memory access, stat merge,
// forwarding outputs and the sticky halted flag.
module memory_wb
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  memory_wb_if.slave        bus
);
  logic        read_req;
  logic        write_req;
  logic        access;
  logic        mem_we;
  logic        dmem_error;
  logic [63:0] mem_addr;
  logic [63:0] rdata;
  w_reg_t      w_q, w_d;
  logic        halted_q, halted_d;

  always_comb begin
    read_req  = (bus.M_icode == I_MRMOVQ) || (bus.M_icode == I_RET) ||
                (bus.M_icode == I_POPQ);
    write_req = (bus.M_icode == I_RMMOVQ) || (bus.M_icode == I_PUSHQ) ||
                (bus.M_icode == I_CALL);
    access    = read_req || write_req;
    mem_addr  = ((bus.M_icode == I_RET) || (bus.M_icode == I_POPQ)) ?
                bus.M_valA : bus.M_valE;
  end

  // Faulting, post-halt and in-reset stores must never reach memory.
  assign mem_we = write_req && (bus.M_stat == STAT_AOK) && !halted_q && !rst;

  data_mem #(.MEM_BYTES(MEM_BYTES)) u_mem (
    .clk          (clk),
    .addr_i       (mem_addr),
    .access_i     (access),
    .we_i         (mem_we),
    .wdata_i      (bus.M_valA),
    .rdata_o      (rdata),
    .dmem_error_o (dmem_error)
  );

  assign bus.m_stat = dmem_error ? STAT_ADR : bus.M_stat;
  assign bus.m_valM = (read_req && !dmem_error) ? rdata : 64'd0;

  always_comb begin
    w_d.stat  = bus.m_stat;
    w_d.icode = bus.M_icode;
    w_d.valE  = bus.M_valE;
    w_d.valM  = bus.m_valM;
    w_d.dstE  = (bus.M_icode == I_CMOVXX && !bus.M_Cnd) ? RNONE : bus.M_dstE;
    w_d.dstM  = bus.M_dstM;
    halted_d  = halted_q || (w_q.stat != STAT_AOK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q      <= W_BUBBLE;
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
      if (!bus.W_stall) begin
        w_q <= w_d;
      end
    end
  end

  assign bus.W_stat  = w_q.stat;
  assign bus.W_icode = w_q.icode;
  assign bus.W_valE  = w_q.valE;
  assign bus.W_valM  = w_q.valM;
  assign bus.W_dstE  = w_q.dstE;
  assign bus.W_dstM  = w_q.dstM;
  assign bus.halted  = halted_q;

endmodule

// File: tb/tb_memory_wb.sv
// Directed self-checking bench for memory_wb: store/load, push/pop,
// cmov squash, W stall, address fault + halt, and reset during stall.
module tb_memory_wb;
  import y86_pkg::*;

  logic clk;
  logic rst;
  int   vecs;
  int   errs;

  memory_wb_if bus ();

  memory_wb #(.MEM_BYTES(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic setM(input logic [0:3] stat, input logic [3:0] icode, input logic cnd,
                      input logic [63:0] valE, input logic [63:0] valA,
                      input logic [3:0] dstE, input logic [3:0] dstM);
    bus.M_stat  = stat;
    bus.M_icode = icode;
    bus.M_Cnd   = cnd;
    bus.M_valE  = valE;
    bus.M_valA  = valA;
    bus.M_dstE  = dstE;
    bus.M_dstM  = dstM;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    setM(STAT_AOK, I_NOP, 1'b0, 64'd0, 64'd0, RNONE, RNONE);
    tick();
    rst = 1'b0;
    vecs++; if (bus.W_stat !== 4'b1000) begin errs++; $display("[TB] FAIL reset_stat got %b want 1000", bus.W_stat); end
    vecs++; if (bus.W_icode !== 4'h1) begin errs++; $display("[TB] FAIL reset_icode got %h want 1", bus.W_icode); end
    vecs++; if (bus.W_valE !== 64'd0 || bus.W_valM !== 64'd0) begin errs++; $display("[TB] FAIL reset_vals got %h/%h want 0/0", bus.W_valE, bus.W_valM); end
    vecs++; if (bus.W_dstE !== 4'hF || bus.W_dstM !== 4'hF) begin errs++; $display("[TB] FAIL reset_dst got %h/%h want f/f", bus.W_dstE, bus.W_dstM); end
    vecs++; if (bus.halted !== 1'b0) begin errs++; $display("[TB] FAIL reset_halted got %b want 0", bus.halted); end
  endtask

  task automatic test_store_load();
    logic [7:0] expByte;
    setM(STAT_AOK, I_RMMOVQ, 1'b0, 64'd16, 64'h1122334455667788, RNONE, RNONE);
    tick();
    for (int k = 0; k < 8; k++) begin
      expByte = 8'h88 - 8'(8'h11 * k);
      vecs++;
      if (dut.u_mem.mem[16 + k] !== expByte) begin
        errs++; $display("[TB] FAIL store_byte%0d got %h want %h", 16 + k, dut.u_mem.mem[16 + k], expByte);
      end
    end
    setM(STAT_AOK, I_MRMOVQ, 1'b0, 64'd16, 64'd0, RNONE, 4'h5);
    vecs++; if (bus.m_valM !== 64'h1122334455667788) begin errs++; $display("[TB] FAIL load_m_valM got %h want 1122334455667788", bus.m_valM); end
    vecs++; if (bus.m_stat !== 4'b1000) begin errs++; $display("[TB] FAIL load_m_stat got %b want 1000", bus.m_stat); end
    tick();
    vecs++; if (bus.W_valM !== 64'h1122334455667788) begin errs++; $display("[TB] FAIL load_W_valM got %h want 1122334455667788", bus.W_valM); end
    vecs++; if (bus.W_dstM !== 4'h5 || bus.W_icode !== 4'h5) begin errs++; $display("[TB] FAIL load_W_dstM_icode got %h/%h want 5/5", bus.W_dstM, bus.W_icode); end
  endtask

  task automatic test_push_pop();
    setM(STAT_AOK, I_PUSHQ, 1'b0, 64'd120, 64'hDEADBEEFCAFEF00D, 4'h4, RNONE);
    tick();
    vecs++; if (bus.W_dstE !== 4'h4 || bus.W_valE !== 64'd120) begin errs++; $display("[TB] FAIL push_W got dstE %h valE %0d want 4/120", bus.W_dstE, bus.W_valE); end
    setM(STAT_AOK, I_POPQ, 1'b0, 64'd128, 64'd120, 4'h4, 4'h7);
    vecs++; if (bus.m_valM !== 64'hDEADBEEFCAFEF00D) begin errs++; $display("[TB] FAIL pop_m_valM got %h want deadbeefcafef00d", bus.m_valM); end
    tick();
    vecs++; if (bus.W_dstE !== 4'h4 || bus.W_dstM !== 4'h7) begin errs++; $display("[TB] FAIL pop_W_dst got %h/%h want 4/7", bus.W_dstE, bus.W_dstM); end
    vecs++; if (bus.W_valM !== 64'hDEADBEEFCAFEF00D || bus.W_valE !== 64'd128) begin errs++; $display("[TB] FAIL pop_W_vals got %h/%h want deadbeefcafef00d/80", bus.W_valM, bus.W_valE); end
  endtask

  task automatic test_cmov();
    setM(STAT_AOK, I_CMOVXX, 1'b0, 64'd55, 64'd55, 4'h3, RNONE);
    tick();
    vecs++; if (bus.W_dstE !== 4'hF) begin errs++; $display("[TB] FAIL cmov_not_taken got %h want f", bus.W_dstE); end
    setM(STAT_AOK, I_CMOVXX, 1'b1, 64'd55, 64'd55, 4'h3, RNONE);
    tick();
    vecs++; if (bus.W_dstE !== 4'h3) begin errs++; $display("[TB] FAIL cmov_taken got %h want 3", bus.W_dstE); end
  endtask

  task automatic test_stall();
    setM(STAT_AOK, I_IRMOVQ, 1'b0, 64'd42, 64'd0, 4'h2, RNONE);
    tick();
    bus.W_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      setM(STAT_AOK, I_OPQ, 1'b0, 64'(100 + i), 64'd0, 4'h6, RNONE);
      tick();
      vecs++;
      if (bus.W_valE !== 64'd42 || bus.W_icode !== 4'h3 || bus.W_dstE !== 4'h2) begin
        errs++; $display("[TB] FAIL stall_hold%0d got valE %0d icode %h dstE %h want 42/3/2", i, bus.W_valE, bus.W_icode, bus.W_dstE);
      end
    end
    setM(STAT_AOK, I_OPQ, 1'b0, 64'd99, 64'd0, 4'h6, RNONE);
    bus.W_stall = 1'b0;
    tick();
    vecs++; if (bus.W_valE !== 64'd99 || bus.W_icode !== 4'h6 || bus.W_dstE !== 4'h6) begin errs++; $display("[TB] FAIL stall_release got valE %0d icode %h dstE %h want 99/6/6", bus.W_valE, bus.W_icode, bus.W_dstE); end
  endtask

  task automatic test_adr_halt();
    setM(STAT_AOK, I_MRMOVQ, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, RNONE, 4'h1);
    vecs++; if (bus.m_stat !== 4'b0010) begin errs++; $display("[TB] FAIL wrap_m_stat got %b want 0010", bus.m_stat); end
    setM(STAT_AOK, I_MRMOVQ, 1'b0, 64'd1020, 64'd0, RNONE, 4'h1);
    vecs++; if (bus.m_stat !== 4'b0010 || bus.m_valM !== 64'd0) begin errs++; $display("[TB] FAIL adr_m got stat %b valM %h want 0010/0", bus.m_stat, bus.m_valM); end
    tick();
    vecs++; if (bus.W_stat !== 4'b0010 || bus.halted !== 1'b0) begin errs++; $display("[TB] FAIL adr_W got stat %b halted %b want 0010/0", bus.W_stat, bus.halted); end
    tick();
    vecs++; if (bus.halted !== 1'b1) begin errs++; $display("[TB] FAIL adr_halted got %b want 1", bus.halted); end
    setM(STAT_AOK, I_RMMOVQ, 1'b0, 64'd16, 64'hFFFF_FFFF_FFFF_FFFF, RNONE, RNONE);
    tick();
    setM(STAT_AOK, I_MRMOVQ, 1'b0, 64'd16, 64'd0, RNONE, 4'h1);
    vecs++; if (bus.m_valM !== 64'h1122334455667788) begin errs++; $display("[TB] FAIL post_halt_store got %h want 1122334455667788", bus.m_valM); end
    vecs++; if (bus.halted !== 1'b1) begin errs++; $display("[TB] FAIL halted_sticky got %b want 1", bus.halted); end
  endtask

  task automatic test_reset_during_stall();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    setM(STAT_AOK, I_IRMOVQ, 1'b0, 64'd77, 64'd0, 4'h1, RNONE);
    tick();
    vecs++; if (bus.W_valE !== 64'd77) begin errs++; $display("[TB] FAIL pre_rst_load got %0d want 77", bus.W_valE); end
    bus.W_stall = 1'b1;
    rst = 1'b1;
    setM(STAT_AOK, I_RMMOVQ, 1'b0, 64'd16, 64'd0, RNONE, RNONE);
    tick();
    rst = 1'b0;
    bus.W_stall = 1'b0;
    vecs++; if (bus.W_stat !== 4'b1000 || bus.W_icode !== 4'h1 || bus.W_valE !== 64'd0 || bus.W_dstE !== 4'hF || bus.W_dstM !== 4'hF) begin
      errs++; $display("[TB] FAIL rst_stall_bubble got stat %b icode %h valE %0d dst %h/%h", bus.W_stat, bus.W_icode, bus.W_valE, bus.W_dstE, bus.W_dstM);
    end
    vecs++; if (bus.halted !== 1'b0) begin errs++; $display("[TB] FAIL rst_stall_halted got %b want 0", bus.halted); end
    setM(STAT_AOK, I_MRMOVQ, 1'b0, 64'd16, 64'd0, RNONE, 4'h2);
    vecs++; if (bus.m_valM !== 64'h1122334455667788) begin errs++; $display("[TB] FAIL rst_mem_kept got %h want 1122334455667788", bus.m_valM); end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst = 1'b1;
    bus.W_stall = 1'b0;
    setM(STAT_AOK, I_NOP, 1'b0, 64'd0, 64'd0, RNONE, RNONE);
    test_reset();
    test_store_load();
    test_push_pop();
    test_cmov();
    test_stall();
    test_adr_halt();
    test_reset_during_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
